surf_clk_manager: RTL and testbench
===================================

# surf_clk_manager

Parametrised clock-manager supervisor for the SURF infrastructure layer, running on the 33 MHz board clock. It sequences resets into NUM_DCM clock managers, watches their lock outputs with timeout and bounded auto-retry, and drives the DCM dynamic phase-shift handshake toward a signed target. It gates the NUM_TREF reference-clock outputs until every DCM is locked, replacing the fixed, unsupervised reset shift register used so far.

## Interface
- NUM_DCM, 2, number of supervised clock managers (1..8)
- NUM_TREF, 4, number of gated TREF enables
- RST_CYCLES, 4, cycles dcm_rst_o is held per attempt (≥3)
- LOCK_TIMEOUT, 16384, cycles allowed from reset release to all-locked
- MAX_RETRIES, 7, failed lock attempts before sticky failure (≤15)
- PS_WIDTH, 9, width of signed phase values
- PS_LIMIT, 255, magnitude clamp on phase target (< 2^(PS_WIDTH-1))
- clk33_i  in  1  33 MHz system clock, sole clock
- clr_all_i  in  1  reset, asynchronous, active-high
- dcm_locked_i  in  NUM_DCM  DCM LOCKED outputs (asynchronous; synchronised internally)
- dcm_rst_o  out  NUM_DCM  DCM reset, all bits identical
- ps_go_i  in  1  single-cycle request to move to ps_target_i
- ps_target_i  in  PS_WIDTH  signed target phase, sampled on ps_go_i
- ps_en_o  out  1  PSEN to DCM 0
- ps_incdec_o  out  1  PSINCDEC to DCM 0 (1 = increment)
- ps_done_i  in  1  PSDONE from DCM 0
- ps_busy_o  out  1  phase move in progress
- ps_current_o  out  PS_WIDTH  signed current applied phase
- ps_limit_o  out  1  last accepted target was clamped
- tref_en_i  in  NUM_TREF  requested TREF enables
- tref_en_o  out  NUM_TREF  tref_en_i AND locked_all_o
- locked_all_o  out  1  FSM in LOCKED
- fail_o  out  1  sticky failure
- retry_cnt_o  out  4  failed attempts in current sequence

## Operation
- dcm_locked_i passes through a 2-flop synchroniser; all_locked = AND of synchronised bits.
- States: RESET, WAIT_LOCK, LOCKED, FAIL.
- RESET: dcm_rst_o = all ones for RST_CYCLES cycles, then WAIT_LOCK with timeout counter cleared.
- WAIT_LOCK: counter increments each cycle; all_locked → LOCKED; counter reaching LOCK_TIMEOUT−1 without lock → retry_cnt+1, then FAIL if new value = MAX_RETRIES, else RESET. all_locked wins if both occur in the same cycle.
- LOCKED: retry_cnt cleared on entry. Any synchronised lock bit low → RESET (lock loss not counted as a retry).
- FAIL: sticky; dcm_rst_o held high; only clr_all_i exits.
- Phase stepper (LOCKED only): ps_go_i while not busy latches target clamped to ±PS_LIMIT, sets ps_limit_o to whether clamping occurred, sets busy. Each step: one-cycle ps_en_o with ps_incdec_o = (current < target), then wait ps_done_i; on ps_done_i update current by ±1. Busy drops the cycle after current equals target. ps_go_i while busy or outside LOCKED is ignored. ps_done_i outside a wait is ignored.
- Leaving LOCKED mid-move: abort, ps_en_o low, busy cleared, ps_current_o reset to 0 (DCM reset restores zero phase); ps_limit_o retained.

## Timing
- Reset values: dcm_rst_o all ones, ps_en_o 0, ps_incdec_o 0, ps_busy_o 0, ps_current_o 0, ps_limit_o 0, tref_en_o 0, locked_all_o 0, fail_o 0, retry_cnt_o 0; FSM in RESET with counter 0.
- All outputs registered; tref_en_o combinational AND of input with registered locked_all_o.
- Lock rise at pin → locked_all_o high within 3 cycles (2 sync + 1 FSM). Lock fall → locked_all_o low and dcm_rst_o high 3 cycles later.
- ps_go_i at cycle n → ps_busy_o at n+1, first ps_en_o at n+2; next ps_en_o no earlier than 1 cycle after ps_done_i. ps_go_i with target = current: busy for exactly one cycle, no ps_en_o.

## Structure
- Package surf_clk_pkg: state enum, clog2-based counter-width function, signed clamp function.
- Sub-module surf_ps_stepper: phase-step handshake, current/target registers, clamp; enabled/aborted by the supervisor FSM.

## Test plan
- Release clr_all_i, lock all DCMs 100 cycles after dcm_rst_o falls → dcm_rst_o high exactly RST_CYCLES, locked_all_o high 3 cycles after lock, tref_en_o = tref_en_i.
- Never lock, MAX_RETRIES=3 → three reset pulses spaced RST_CYCLES+LOCK_TIMEOUT, fail_o high, retry_cnt_o=3, dcm_rst_o stuck high until clr_all_i.
- Locked, ps_go_i target=+5, PSDONE 3 cycles after each PSEN → five incdec=1 pulses, ps_current_o=5, busy clear; then target −300 → clamped to −255, ps_limit_o=1, 260 decrements.
- Drop dcm_locked_i[1] mid-move at current=3 → ps_en_o stops, ps_current_o=0, tref_en_o low within 3 cycles, new RESET pulse, retry_cnt_o unchanged.
- Lock asserted on the timeout cycle → LOCKED entered, no retry counted.
- ps_go_i while busy or in WAIT_LOCK → ignored, target unchanged.

Source files
------------

// File: rtl/surf_clk_pkg.sv
// Shared types and helpers for the SURF clock-manager supervisor.
package surf_clk_pkg;

   // Supervisor FSM states
   typedef enum logic [1:0] {
      ST_RESET     = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_LOCKED    = 2'd2,
      ST_FAIL      = 2'd3
   } sup_state_e;

   // Width needed for a counter that runs 0..n-1 (at least one bit)
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Clamp a signed value to +/-lim
   function automatic int clamp_s(input int v, input int lim);
      if (v > lim)       return lim;
      else if (v < -lim) return -lim;
      else               return v;
   endfunction

endpackage

// File: rtl/surf_ps_stepper.sv
// DCM dynamic phase-shift stepper: walks the applied phase one PSEN/PSDONE
// handshake at a time toward a clamped signed target. Dropping en_i aborts
// any move and returns the phase to zero, matching a DCM reset.
module surf_ps_stepper
   import surf_clk_pkg::*;
#(
   parameter int PS_WIDTH = 9,
   parameter int PS_LIMIT = 255
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic                       go_i,
   input  logic signed [PS_WIDTH-1:0] target_i,
   input  logic                       done_i,
   output logic                       ps_en_o,
   output logic                       ps_incdec_o,
   output logic                       busy_o,
   output logic signed [PS_WIDTH-1:0] current_o,
   output logic                       limit_o
);

   logic signed [PS_WIDTH-1:0] cur_q;
   logic signed [PS_WIDTH-1:0] tgt_q;
   logic                       busy_q;
   logic                       wait_q;
   logic                       en_q;
   logic                       incdec_q;
   logic                       limit_q;
   int                         tgt_int;
   int                         tgt_lim;
   logic                       clamped;

   // Clamp the requested target before it is latched
   always_comb begin
      tgt_int = int'(target_i);
      tgt_lim = clamp_s(tgt_int, PS_LIMIT);
   end
   assign clamped = (tgt_lim != tgt_int);

   // Step handshake: idle -> issue PSEN -> wait PSDONE -> re-evaluate
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cur_q    <= '0;
         tgt_q    <= '0;
         busy_q   <= 1'b0;
         wait_q   <= 1'b0;
         en_q     <= 1'b0;
         incdec_q <= 1'b0;
         limit_q  <= 1'b0;
      end else if (!en_i) begin
         // Outside LOCKED: abort; the limit flag is kept for software
         cur_q  <= '0;
         busy_q <= 1'b0;
         wait_q <= 1'b0;
         en_q   <= 1'b0;
      end else begin
         en_q <= 1'b0;
         if (!busy_q) begin
            if (go_i) begin
               tgt_q   <= PS_WIDTH'(tgt_lim);
               limit_q <= clamped;
               busy_q  <= 1'b1;
            end
         end else if (wait_q) begin
            if (done_i) begin
               cur_q  <= incdec_q ? cur_q + 1'b1 : cur_q - 1'b1;
               wait_q <= 1'b0;
            end
         end else if (cur_q == tgt_q) begin
            busy_q <= 1'b0;
         end else begin
            en_q     <= 1'b1;
            incdec_q <= (cur_q < tgt_q);
            wait_q   <= 1'b1;
         end
      end
   end

   assign ps_en_o     = en_q;
   assign ps_incdec_o = incdec_q;
   assign busy_o      = busy_q;
   assign current_o   = cur_q;
   assign limit_o     = limit_q;

endmodule

// File: rtl/surf_clk_manager.sv
// Clock-manager supervisor: sequences DCM resets, supervises lock with
// timeout and bounded retry, gates TREF enables and owns the phase stepper.
module surf_clk_manager
   import surf_clk_pkg::*;
#(
   parameter int NUM_DCM      = 2,
   parameter int NUM_TREF     = 4,
   parameter int RST_CYCLES   = 4,
   parameter int LOCK_TIMEOUT = 16384,
   parameter int MAX_RETRIES  = 7,
   parameter int PS_WIDTH     = 9,
   parameter int PS_LIMIT     = 255
) (
   input  logic                       clk33_i,
   input  logic                       clr_all_i,
   input  logic [NUM_DCM-1:0]         dcm_locked_i,
   output logic [NUM_DCM-1:0]         dcm_rst_o,
   input  logic                       ps_go_i,
   input  logic signed [PS_WIDTH-1:0] ps_target_i,
   output logic                       ps_en_o,
   output logic                       ps_incdec_o,
   input  logic                       ps_done_i,
   output logic                       ps_busy_o,
   output logic signed [PS_WIDTH-1:0] ps_current_o,
   output logic                       ps_limit_o,
   input  logic [NUM_TREF-1:0]        tref_en_i,
   output logic [NUM_TREF-1:0]        tref_en_o,
   output logic                       locked_all_o,
   output logic                       fail_o,
   output logic [3:0]                 retry_cnt_o
);

   // One counter serves both the reset hold and the lock timeout
   localparam int             CNT_MAX   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int             CW        = cnt_width(CNT_MAX);
   localparam logic [CW-1:0]  RST_LAST  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0]  TO_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [3:0]     RETRY_MAX = 4'(MAX_RETRIES);

   logic [NUM_DCM-1:0] sync1_q;
   logic [NUM_DCM-1:0] sync2_q;
   logic               all_locked;
   sup_state_e         state_q;
   logic [CW-1:0]      cnt_q;
   logic [3:0]         retry_q;
   logic               rst_q;
   logic               locked_q;
   logic               fail_q;

   // Two-flop synchroniser for the asynchronous LOCKED pins
   always_ff @(posedge clk33_i or posedge clr_all_i) begin
      if (clr_all_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= dcm_locked_i;
         sync2_q <= sync1_q;
      end
   end

   assign all_locked = &sync2_q;

   // Supervisor FSM with registered outputs
   always_ff @(posedge clk33_i or posedge clr_all_i) begin
      if (clr_all_i) begin
         state_q  <= ST_RESET;
         cnt_q    <= '0;
         retry_q  <= '0;
         rst_q    <= 1'b1;
         locked_q <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_RESET: begin
               if (cnt_q == RST_LAST) begin
                  state_q <= ST_WAIT_LOCK;
                  cnt_q   <= '0;
                  rst_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock takes priority over a coincident timeout
               if (all_locked) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                  retry_q  <= '0;
               end else if (cnt_q == TO_LAST) begin
                  retry_q <= retry_q + 1'b1;
                  cnt_q   <= '0;
                  rst_q   <= 1'b1;
                  if (retry_q + 4'd1 == RETRY_MAX) begin
                     state_q <= ST_FAIL;
                     fail_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RESET;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_LOCKED: begin
               // Lock loss restarts the sequence without costing a retry
               if (!all_locked) begin
                  state_q  <= ST_RESET;
                  cnt_q    <= '0;
                  rst_q    <= 1'b1;
                  locked_q <= 1'b0;
               end
            end
            ST_FAIL: begin
               rst_q <= 1'b1;
            end
            default: begin
               state_q  <= ST_RESET;
               cnt_q    <= '0;
               rst_q    <= 1'b1;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   surf_ps_stepper #(
      .PS_WIDTH (PS_WIDTH),
      .PS_LIMIT (PS_LIMIT)
   ) u_stepper (
      .clk_i       (clk33_i),
      .rst_i       (clr_all_i),
      .en_i        (locked_q),
      .go_i        (ps_go_i),
      .target_i    (ps_target_i),
      .done_i      (ps_done_i),
      .ps_en_o     (ps_en_o),
      .ps_incdec_o (ps_incdec_o),
      .busy_o      (ps_busy_o),
      .current_o   (ps_current_o),
      .limit_o     (ps_limit_o)
   );

   assign dcm_rst_o    = {NUM_DCM{rst_q}};
   assign tref_en_o    = tref_en_i & {NUM_TREF{locked_q}};
   assign locked_all_o = locked_q;
   assign fail_o       = fail_q;
   assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_surf_clk_manager.sv
// Directed bench for surf_clk_manager with a PSDONE responder that checks
// each PSEN step against a queue of expected step directions.
module tb_surf_clk_manager;

   localparam int NUM_DCM      = 2;
   localparam int NUM_TREF     = 4;
   localparam int RST_CYCLES   = 4;
   localparam int LOCK_TIMEOUT = 256;
   localparam int MAX_RETRIES  = 3;
   localparam int PS_WIDTH     = 10;
   localparam int PS_LIMIT     = 255;

   logic                       clk;
   logic                       clr;
   logic [NUM_DCM-1:0]         locked;
   logic [NUM_DCM-1:0]         dcm_rst;
   logic                       ps_go;
   logic signed [PS_WIDTH-1:0] ps_target;
   logic                       ps_en;
   logic                       ps_incdec;
   logic                       ps_done;
   logic                       ps_busy;
   logic signed [PS_WIDTH-1:0] ps_current;
   logic                       ps_limit;
   logic [NUM_TREF-1:0]        tref_in;
   logic [NUM_TREF-1:0]        tref_out;
   logic                       locked_all;
   logic                       fail;
   logic [3:0]                 retry;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];
   logic exp_bit;

   surf_clk_manager #(
      .NUM_DCM      (NUM_DCM),
      .NUM_TREF     (NUM_TREF),
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .MAX_RETRIES  (MAX_RETRIES),
      .PS_WIDTH     (PS_WIDTH),
      .PS_LIMIT     (PS_LIMIT)
   ) dut (
      .clk33_i      (clk),
      .clr_all_i    (clr),
      .dcm_locked_i (locked),
      .dcm_rst_o    (dcm_rst),
      .ps_go_i      (ps_go),
      .ps_target_i  (ps_target),
      .ps_en_o      (ps_en),
      .ps_incdec_o  (ps_incdec),
      .ps_done_i    (ps_done),
      .ps_busy_o    (ps_busy),
      .ps_current_o (ps_current),
      .ps_limit_o   (ps_limit),
      .tref_en_i    (tref_in),
      .tref_en_o    (tref_out),
      .locked_all_o (locked_all),
      .fail_o       (fail),
      .retry_cnt_o  (retry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count consecutive samples (starting now) where dcm_rst all-ones equals val
   task automatic count_while(input logic val, input int limit, output int n);
      n = 0;
      while (((&dcm_rst) == val) && (n < limit)) begin
         n++;
         tick();
      end
   endtask

   task automatic wait_idle(input int limit, output logic ok);
      int n;
      n = 0;
      while (ps_busy && (n < limit)) begin
         n++;
         tick();
      end
      ok = !ps_busy;
   endtask

   // DCM 0 phase-shift model: PSDONE three cycles after each PSEN,
   // direction checked against the scoreboard
   initial ps_done = 1'b0;
   always begin
      @(posedge clk);
      #2;
      if (ps_en === 1'b1) begin
         chk("ps_step_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            exp_bit = exp_q.pop_front();
            chk("ps_incdec", ps_incdec, exp_bit);
         end
         repeat (3) @(posedge clk);
         #2 ps_done = 1'b1;
         @(posedge clk);
         #2 ps_done = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic ok;
      logic any_en;

      clr = 1'b1; locked = '0; ps_go = 1'b0; ps_target = '0; tref_in = 4'hF;
      repeat (3) tick();

      // Reset values
      chk("rst_dcm_rst", dcm_rst, 2'b11);
      chk("rst_ps_en", ps_en, 0);
      chk("rst_incdec", ps_incdec, 0);
      chk("rst_busy", ps_busy, 0);
      chk("rst_current", ps_current, 0);
      chk("rst_limit", ps_limit, 0);
      chk("rst_tref", tref_out, 0);
      chk("rst_locked", locked_all, 0);
      chk("rst_fail", fail, 0);
      chk("rst_retry", retry, 0);

      // Reset pulse length, then lock 100 cycles later
      clr = 1'b0;
      count_while(1'b1, 50, n);
      chk("rst_pulse_len", n, RST_CYCLES);
      repeat (99) tick();
      chk("no_lock_yet", locked_all, 0);
      locked = 2'b11;
      repeat (2) tick();
      chk("lock_lat_2", locked_all, 0);
      tick();
      chk("lock_lat_3", locked_all, 1);
      chk("tref_pass_f", tref_out, 4'hF);
      tref_in = 4'b1010;
      #1;
      chk("tref_pass_a", tref_out, 4'b1010);
      chk("locked_dcm_rst", dcm_rst, 0);
      chk("locked_retry", retry, 0);

      // Move to +5
      repeat (5) exp_q.push_back(1'b1);
      ps_target = PS_WIDTH'(5); ps_go = 1'b1;
      tick();
      ps_go = 1'b0;
      chk("go_busy_n1", ps_busy, 1);
      chk("go_noen_n1", ps_en, 0);
      tick();
      chk("go_en_n2", ps_en, 1);
      wait_idle(200, ok);
      chk("move5_done", ok, 1);
      chk("cur_5", ps_current, 5);
      chk("limit_5", ps_limit, 0);
      chk("sb_empty_5", exp_q.size(), 0);

      // Move to -300, clamped to -255; a go while busy is ignored
      repeat (260) exp_q.push_back(1'b0);
      ps_target = PS_WIDTH'(-300); ps_go = 1'b1;
      tick();
      ps_go = 1'b0;
      chk("clamp_busy", ps_busy, 1);
      chk("clamp_limit", ps_limit, 1);
      repeat (10) tick();
      ps_target = PS_WIDTH'(100); ps_go = 1'b1;
      tick();
      ps_go = 1'b0;
      wait_idle(3000, ok);
      chk("move_neg_done", ok, 1);
      chk("cur_neg255", ps_current, -255);
      chk("limit_kept_busy_go", ps_limit, 1);
      chk("sb_empty_neg", exp_q.size(), 0);

      // Clamped move to +300; lose DCM 1 lock at current = 3
      repeat (510) exp_q.push_back(1'b1);
      ps_target = PS_WIDTH'(300); ps_go = 1'b1;
      tick();
      ps_go = 1'b0;
      n = 0;
      while ((ps_current != 3) && (n < 3000)) begin
         n++;
         tick();
      end
      chk("reach_3", ps_current, 3);
      locked = 2'b01;
      repeat (2) tick();
      chk("loss_lat_2", locked_all, 1);
      tick();
      chk("loss_locked", locked_all, 0);
      chk("loss_tref", tref_out, 0);
      chk("loss_dcm_rst", dcm_rst, 2'b11);
      tick();
      chk("abort_cur", ps_current, 0);
      chk("abort_busy", ps_busy, 0);
      chk("abort_en", ps_en, 0);
      chk("abort_limit", ps_limit, 1);
      exp_q.delete();
      // one pulse cycle already elapsed before counting
      count_while(1'b1, 50, n);
      chk("loss_pulse_len", n, RST_CYCLES - 1);
      chk("loss_retry", retry, 0);

      // go in WAIT_LOCK is ignored
      ps_target = PS_WIDTH'(50); ps_go = 1'b1;
      tick();
      ps_go = 1'b0;
      chk("wait_go_busy", ps_busy, 0);
      any_en = 1'b0;
      repeat (20) begin
         tick();
         if (ps_en) any_en = 1'b1;
      end
      chk("wait_go_no_en", any_en, 0);

      // Relock, then a go to the current phase is busy for one cycle
      locked = 2'b11;
      repeat (3) tick();
      chk("relock", locked_all, 1);
      chk("relock_busy", ps_busy, 0);
      ps_target = PS_WIDTH'(0); ps_go = 1'b1;
      tick();
      ps_go = 1'b0;
      chk("same_busy_n1", ps_busy, 1);
      chk("same_limit", ps_limit, 0);
      tick();
      chk("same_busy_n2", ps_busy, 0);
      chk("same_no_en", ps_en, 0);
      chk("same_cur", ps_current, 0);

      // Never lock: three attempts then sticky FAIL
      locked = '0; clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int k = 0; k < MAX_RETRIES; k++) begin
         count_while(1'b1, 50, n);
         chk("retry_pulse_len", n, RST_CYCLES);
         count_while(1'b0, 1000, n);
         chk("retry_wait_len", n, LOCK_TIMEOUT);
         chk("retry_cnt", retry, k + 1);
      end
      chk("fail_set", fail, 1);
      chk("fail_retry", retry, MAX_RETRIES);
      count_while(1'b1, 50, n);
      chk("fail_rst_stuck", n, 50);
      chk("fail_not_locked", locked_all, 0);

      // Clear, one timeout, then lock arrives exactly on the timeout cycle
      clr = 1'b1;
      tick();
      chk("clr_fail", fail, 0);
      chk("clr_retry", retry, 0);
      clr = 1'b0;
      count_while(1'b1, 50, n);
      chk("edge_pulse1", n, RST_CYCLES);
      count_while(1'b0, 1000, n);
      chk("edge_wait1", n, LOCK_TIMEOUT);
      chk("edge_retry1", retry, 1);
      count_while(1'b1, 50, n);
      chk("edge_pulse2", n, RST_CYCLES);
      repeat (LOCK_TIMEOUT - 3) tick();
      locked = 2'b11;
      repeat (3) tick();
      chk("edge_locked", locked_all, 1);
      chk("edge_no_rst", dcm_rst, 0);
      chk("edge_retry_clr", retry, 0);
      chk("edge_no_fail", fail, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
